// File: rtl/dff_bist_ctrl.sv
// Built-in self-test controller for one D flip-flop: walks a bit pattern through D,
// checks Q one cycle later, then proves the flop's synchronous reset and reports pass/fail.
module dff_bist_ctrl #(
  parameter int          PAT_LEN = 8,
  parameter logic [31:0] PATTERN = 32'h0000_00B4,
  parameter int          RST_CYC = 2,
  parameter int          ERR_W   = 4
) (
  input  logic             CLK,
  input  logic             n_res,
  input  logic             start,
  input  logic             q_in,
  output logic             d_out,
  output logic             dut_n_res,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_cnt,
  output logic [2:0]       state_dbg
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    DRIVE    = 3'd1,
    CHECK    = 3'd2,
    RST_HOLD = 3'd3,
    RST_CHK  = 3'd4,
    RELEASE  = 3'd5,
    FIN      = 3'd6
  } state_t;

  localparam logic [4:0]       LAST_STEP = 5'(PAT_LEN - 1);
  localparam logic [7:0]       HOLD_LAST = 8'(RST_CYC - 2);
  localparam logic [ERR_W-1:0] ERR_MAX   = '1;

  state_t           state, state_nxt;
  logic [4:0]       step, step_nxt;
  logic [7:0]       hold, hold_nxt;
  logic             d_nxt, nres_nxt, busy_nxt, done_nxt, pass_nxt;
  logic [ERR_W-1:0] err_nxt;
  logic             accept;
  logic             mismatch;

  // A start coinciding with the done pulse is dropped so the result stays visible for a cycle.
  assign accept    = (state == IDLE) && start && !done;
  assign state_dbg = state;

  // Unknown Q must count as a failure, hence the case-inequality compares.
  always_comb begin
    mismatch = 1'b0;
    if (state == CHECK)
      mismatch = (q_in !== PATTERN[step]);
    else if (state == RST_CHK)
      mismatch = (q_in !== 1'b0);
  end

  always_ff @(posedge CLK) begin
    if (!n_res) begin
      state     <= IDLE;
      step      <= '0;
      hold      <= '0;
      d_out     <= 1'b0;
      dut_n_res <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      err_cnt   <= '0;
    end else begin
      state     <= state_nxt;
      step      <= step_nxt;
      hold      <= hold_nxt;
      d_out     <= d_nxt;
      dut_n_res <= nres_nxt;
      busy      <= busy_nxt;
      done      <= done_nxt;
      pass      <= pass_nxt;
      err_cnt   <= err_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    step_nxt  = step;
    hold_nxt  = hold;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = DRIVE;
          step_nxt  = '0;
        end
      end
      DRIVE:   state_nxt = CHECK;
      CHECK: begin
        if (step == LAST_STEP) begin
          state_nxt = RST_HOLD;
          hold_nxt  = '0;
        end else begin
          state_nxt = DRIVE;
          step_nxt  = step + 5'd1;
        end
      end
      RST_HOLD: begin
        if (hold == HOLD_LAST)
          state_nxt = RST_CHK;
        else
          hold_nxt = hold + 8'd1;
      end
      RST_CHK: state_nxt = RELEASE;
      RELEASE: state_nxt = FIN;
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Registered outputs are loaded from the state being entered, so D is stable for the
  // whole DRIVE cycle and the flop captures it on the edge leaving DRIVE.
  always_comb begin
    d_nxt    = 1'b0;
    nres_nxt = 1'b1;
    case (state_nxt)
      DRIVE:            d_nxt = PATTERN[step_nxt];
      CHECK:            d_nxt = d_out;
      RST_HOLD,
      RST_CHK: begin
        d_nxt    = 1'b1;
        nres_nxt = 1'b0;
      end
      default: begin
        d_nxt    = 1'b0;
        nres_nxt = 1'b1;
      end
    endcase

    busy_nxt = (state_nxt != IDLE);
    done_nxt = (state == FIN);

    pass_nxt = pass;
    if (accept)
      pass_nxt = 1'b0;
    else if (state == FIN)
      pass_nxt = (err_cnt == '0);

    err_nxt = err_cnt;
    if (accept)
      err_nxt = '0;
    else if (mismatch && (err_cnt != ERR_MAX))
      err_nxt = err_cnt + 1'b1;
  end

endmodule

// File: tb/tb_dff_bist_ctrl.sv
// Directed bench for dff_bist_ctrl: two controllers (ERR_W=4 and ERR_W=2) each drive a
// behavioural flop whose fault mode is selected per scenario.
module tb_dff_bist_ctrl;

  logic       CLK = 1'b0;
  logic       n_res = 1'b0;
  logic       start = 1'b0;
  int         mode = 0;  // 0 good, 1 stuck-at-0, 2 stuck-at-1, 3 ignores reset

  logic       q_a = 1'b0, d_a, nr_a, busy_a, done_a, pass_a;
  logic [3:0] err_a;
  logic [2:0] st_a;
  logic       q_b = 1'b0, d_b, nr_b, busy_b, done_b, pass_b;
  logic [1:0] err_b;
  logic [2:0] st_b;

  int total = 0;
  int bad   = 0;

  int         done_at;
  int         pulses;
  logic [7:0] d_seq;
  logic [8:0] snap;
  logic       exp_q[$];

  always #5 CLK = ~CLK;

  dff_bist_ctrl u_a (
    .CLK(CLK), .n_res(n_res), .start(start), .q_in(q_a),
    .d_out(d_a), .dut_n_res(nr_a), .busy(busy_a), .done(done_a),
    .pass(pass_a), .err_cnt(err_a), .state_dbg(st_a)
  );

  dff_bist_ctrl #(.ERR_W(2)) u_b (
    .CLK(CLK), .n_res(n_res), .start(start), .q_in(q_b),
    .d_out(d_b), .dut_n_res(nr_b), .busy(busy_b), .done(done_b),
    .pass(pass_b), .err_cnt(err_b), .state_dbg(st_b)
  );

  always @(posedge CLK) begin
    case (mode)
      1:       begin q_a <= 1'b0; q_b <= 1'b0; end
      2:       begin q_a <= 1'b1; q_b <= 1'b1; end
      3:       begin q_a <= d_a;  q_b <= d_b;  end
      default: begin q_a <= nr_a ? d_a : 1'b0; q_b <= nr_b ? d_b : 1'b0; end
    endcase
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic apply_reset();
    n_res = 1'b0;
    start = 1'b0;
    tick();
    tick();
    n_res = 1'b1;
    tick();
  endtask

  // Edge k=0 samples the start pulse; later edges optionally re-pulse start or pull n_res low.
  task automatic do_run(input int restart_at, input int abort_at, input int n_cyc);
    start = 1'b1;
    tick();
    start   = 1'b0;
    done_at = -1;
    pulses  = 0;
    d_seq   = '0;
    snap    = '1;
    d_seq[0] = d_a;
    for (int k = 1; k <= n_cyc; k++) begin
      start = (k == restart_at);
      n_res = (k == abort_at) ? 1'b0 : 1'b1;
      tick();
      start = 1'b0;
      n_res = 1'b1;
      if (k < 16 && (k % 2) == 0) d_seq[k/2] = d_a;
      if (done_a) begin
        pulses++;
        if (done_at < 0) done_at = k;
      end
      if (k == abort_at) snap = {d_a, nr_a, busy_a, done_a, pass_a, err_a};
    end
  endtask

  task automatic test_reset();
    mode  = 0;
    n_res = 1'b0;
    start = 1'b0;
    tick();
    tick();
    total++; if (d_a !== 1'b0)  begin bad++; $display("FAIL rst_d_out got=%b want=0", d_a); end
    total++; if (nr_a !== 1'b0) begin bad++; $display("FAIL rst_dut_n_res got=%b want=0", nr_a); end
    total++; if ({busy_a, done_a, pass_a} !== 3'b000)
      begin bad++; $display("FAIL rst_flags got=%b want=000", {busy_a, done_a, pass_a}); end
    total++; if (err_a !== 4'd0) begin bad++; $display("FAIL rst_err got=%0d want=0", err_a); end
    total++; if (st_a !== 3'd0)  begin bad++; $display("FAIL rst_state got=%0d want=0", st_a); end
    n_res = 1'b1;
    tick();
    total++; if (nr_a !== 1'b1) begin bad++; $display("FAIL idle_dut_n_res got=%b want=1", nr_a); end
    total++; if (busy_a !== 1'b0) begin bad++; $display("FAIL idle_busy got=%b want=0", busy_a); end
  endtask

  task automatic test_good();
    logic [7:0] seq_exp;
    mode = 0;
    apply_reset();
    exp_q = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    seq_exp = '0;
    for (int i = 0; i < 8; i++) seq_exp[i] = exp_q.pop_front();
    do_run(0, 0, 24);
    total++; if (d_seq !== seq_exp) begin bad++; $display("FAIL good_d_seq got=%b want=%b", d_seq, seq_exp); end
    total++; if (done_at != 20) begin bad++; $display("FAIL good_done_at got=%0d want=20", done_at); end
    total++; if (pulses != 1)   begin bad++; $display("FAIL good_pulses got=%0d want=1", pulses); end
    total++; if (pass_a !== 1'b1) begin bad++; $display("FAIL good_pass got=%b want=1", pass_a); end
    total++; if (err_a !== 4'd0)  begin bad++; $display("FAIL good_err got=%0d want=0", err_a); end
    total++; if (busy_a !== 1'b0) begin bad++; $display("FAIL good_busy_after got=%b want=0", busy_a); end
    total++; if ({pass_b, err_b} !== 3'b100)
      begin bad++; $display("FAIL good_b_result got=%b want=100", {pass_b, err_b}); end
  endtask

  task automatic test_stuck0();
    mode = 1;
    apply_reset();
    do_run(0, 0, 24);
    total++; if (err_a !== 4'd4)  begin bad++; $display("FAIL s0_err got=%0d want=4", err_a); end
    total++; if (pass_a !== 1'b0) begin bad++; $display("FAIL s0_pass got=%b want=0", pass_a); end
    total++; if (done_at != 20)   begin bad++; $display("FAIL s0_done_at got=%0d want=20", done_at); end
  endtask

  task automatic test_no_reset();
    mode = 3;
    apply_reset();
    do_run(0, 0, 24);
    total++; if (err_a !== 4'd1)  begin bad++; $display("FAIL norst_err got=%0d want=1", err_a); end
    total++; if (pass_a !== 1'b0) begin bad++; $display("FAIL norst_pass got=%b want=0", pass_a); end
  endtask

  task automatic test_stuck1_sat();
    mode = 2;
    apply_reset();
    do_run(0, 0, 24);
    total++; if (err_b !== 2'd3)  begin bad++; $display("FAIL s1_sat_err got=%0d want=3", err_b); end
    total++; if (pass_b !== 1'b0) begin bad++; $display("FAIL s1_sat_pass got=%b want=0", pass_b); end
    total++; if (err_a !== 4'd5)  begin bad++; $display("FAIL s1_err got=%0d want=5", err_a); end
  endtask

  task automatic test_restart();
    mode = 0;
    apply_reset();
    do_run(7, 0, 24);
    total++; if (done_at != 20) begin bad++; $display("FAIL restart_done_at got=%0d want=20", done_at); end
    total++; if (pulses != 1)   begin bad++; $display("FAIL restart_pulses got=%0d want=1", pulses); end
    total++; if ({pass_a, err_a} !== 5'b1_0000)
      begin bad++; $display("FAIL restart_result got=%b want=10000", {pass_a, err_a}); end
  endtask

  task automatic test_abort();
    mode = 0;
    apply_reset();
    do_run(0, 10, 24);
    total++; if (snap !== 9'd0) begin bad++; $display("FAIL abort_snap got=%b want=000000000", snap); end
    total++; if (pulses != 0)   begin bad++; $display("FAIL abort_pulses got=%0d want=0", pulses); end
    do_run(0, 0, 24);
    total++; if (done_at != 20) begin bad++; $display("FAIL abort_rerun_done got=%0d want=20", done_at); end
    total++; if ({pass_a, err_a} !== 5'b1_0000)
      begin bad++; $display("FAIL abort_rerun_result got=%b want=10000", {pass_a, err_a}); end
  endtask

  task automatic test_back_to_back();
    int dn;
    mode = 0;
    apply_reset();
    do_run(0, 0, 20);
    total++; if (done_a !== 1'b1) begin bad++; $display("FAIL b2b_done_now got=%b want=1", done_a); end
    start = 1'b1;
    tick();
    total++; if (busy_a !== 1'b0) begin bad++; $display("FAIL b2b_start_on_done got=%b want=0", busy_a); end
    total++; if (pass_a !== 1'b1) begin bad++; $display("FAIL b2b_pass_held got=%b want=1", pass_a); end
    tick();
    start = 1'b0;
    total++; if (busy_a !== 1'b1) begin bad++; $display("FAIL b2b_accept got=%b want=1", busy_a); end
    total++; if (pass_a !== 1'b0) begin bad++; $display("FAIL b2b_pass_clear got=%b want=0", pass_a); end
    dn = 0;
    for (int i = 0; i < 25; i++) begin
      tick();
      if (done_a) dn++;
    end
    total++; if (dn != 1) begin bad++; $display("FAIL b2b_second_done got=%0d want=1", dn); end
  endtask

  initial begin
    test_reset();
    test_good();
    test_stuck0();
    test_no_reset();
    test_stuck1_sat();
    test_restart();
    test_abort();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
